// File: rtl/shape_seq_ctrl_pkg.sv
// Shared types and constants for the OLED shape-display datapath:
// shape indices, panel geometry, RGB565 colours and sequencer encodings.
package shape_pkg;

  localparam int unsigned OLED_W = 96;
  localparam int unsigned OLED_H = 64;
  localparam int unsigned PIX_W  = 13;

  typedef logic [2:0] shape_t;

  localparam shape_t SHAPE_BLANK    = 3'd0;
  localparam shape_t SHAPE_CIRCLE_G = 3'd1;
  localparam shape_t SHAPE_CIRCLE_O = 3'd2;
  localparam shape_t SHAPE_CIRCLE_R = 3'd3;
  localparam shape_t SHAPE_SQUARE_G = 3'd4;
  localparam shape_t SHAPE_SQUARE_O = 3'd5;
  localparam shape_t SHAPE_SQUARE_R = 3'd6;

  localparam logic [15:0] ORANGE = 16'hFC00;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] WHITE  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } seq_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Index arithmetic is mod 8: up 7->0, down 0->7.
  function automatic shape_t shape_step(shape_t s, dir_e d);
    return (d == DIR_UP) ? shape_t'(s + 3'd1) : shape_t'(s - 3'd1);
  endfunction

  function automatic logic is_square(shape_t s);
    return (s >= SHAPE_SQUARE_G) && (s <= SHAPE_SQUARE_R);
  endfunction

endpackage

// File: rtl/shape_seq_ctrl_if.sv
// Button/pixel inputs and shape-select outputs of the shape sequencer.
interface shape_seq_ctrl_if;
  import shape_pkg::*;

  logic             tick_1k;
  logic             btn_up;
  logic             btn_down;
  logic [PIX_W-1:0] pixel_index;
  shape_t           shape_sel;
  logic             doughnut_white;
  shape_t           pending_sel;
  logic             commit_pulse;

  modport master (
    output tick_1k, btn_up, btn_down, pixel_index,
    input  shape_sel, doughnut_white, pending_sel, commit_pulse
  );

  modport slave (
    input  tick_1k, btn_up, btn_down, pixel_index,
    output shape_sel, doughnut_white, pending_sel, commit_pulse
  );
endinterface

// File: rtl/shape_seq_ctrl_btn_debounce.sv
// Tick-based debouncer: a level is accepted after DEBOUNCE_MS consecutive
// differing tick_1k samples; an accepted rising edge yields a one-clk press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1k,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (tick_1k) begin
      if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        level_d = raw;
        cnt_d   = '0;
        press_d = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/shape_seq_ctrl.sv
// Shape sequencer: debounced up/down with hold-to-repeat steps a pending
// index, which is committed to the pixel mux only at frame start.
module shape_seq_ctrl
  import shape_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS     = 200,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 150,
  parameter int unsigned FRAME_PIXELS    = OLED_W * OLED_H
) (
  input  logic             clk,
  input  logic             rst,
  shape_seq_ctrl_if.slave  bus
);

  localparam int unsigned HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                     REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY_MS - 1);
  localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE_MS - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(FRAME_PIXELS - 1);

  logic up_level, up_press, dn_level, dn_press;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_up (
    .clk     (clk),
    .rst     (rst),
    .tick_1k (bus.tick_1k),
    .raw     (bus.btn_up),
    .level   (up_level),
    .press   (up_press)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_dn (
    .clk     (clk),
    .rst     (rst),
    .tick_1k (bus.tick_1k),
    .raw     (bus.btn_down),
    .level   (dn_level),
    .press   (dn_press)
  );

  seq_state_e       state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  shape_t           pending_q, pending_d;
  shape_t           shape_q, shape_d;
  logic             dw_q, dw_d;
  logic             commit_q, commit_d;
  logic [PIX_W-1:0] prev_pix_q, prev_pix_d;

  logic              step_en;
  logic              held_level;
  logic [HOLD_W-1:0] hold_last;
  logic              pix_ok;
  logic              frame_start;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    hold_cnt_d = hold_cnt_q;
    step_en    = 1'b0;
    held_level = (dir_q == DIR_UP) ? up_level : dn_level;
    hold_last  = (state_q == ST_HOLD) ? DELAY_LAST : RATE_LAST;

    unique case (state_q)
      ST_IDLE: begin
        // Coincident presses cancel out rather than picking a winner.
        if (up_press ^ dn_press) begin
          state_d    = ST_HOLD;
          dir_d      = up_press ? DIR_UP : DIR_DOWN;
          hold_cnt_d = '0;
          step_en    = 1'b1;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!held_level) begin
          state_d = ST_IDLE;
        end else if (bus.tick_1k) begin
          if (hold_cnt_q == hold_last) begin
            state_d    = ST_REPEAT;
            hold_cnt_d = '0;
            step_en    = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d = step_en ? shape_step(pending_q, dir_d) : pending_q;
  end

  // Out-of-range pixel indices leave the previous-index register untouched.
  always_comb begin
    pix_ok      = (bus.pixel_index <= PIX_LAST);
    frame_start = (bus.pixel_index == '0) && (prev_pix_q != '0);
    prev_pix_d  = pix_ok ? bus.pixel_index : prev_pix_q;
    shape_d     = frame_start ? pending_q : shape_q;
    dw_d        = frame_start ? is_square(pending_q) : dw_q;
    commit_d    = frame_start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_UP;
      hold_cnt_q <= '0;
      pending_q  <= SHAPE_BLANK;
      shape_q    <= SHAPE_BLANK;
      dw_q       <= 1'b0;
      commit_q   <= 1'b0;
      prev_pix_q <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      hold_cnt_q <= hold_cnt_d;
      pending_q  <= pending_d;
      shape_q    <= shape_d;
      dw_q       <= dw_d;
      commit_q   <= commit_d;
      prev_pix_q <= prev_pix_d;
    end
  end

  assign bus.shape_sel      = shape_q;
  assign bus.doughnut_white = dw_q;
  assign bus.pending_sel    = pending_q;
  assign bus.commit_pulse   = commit_q;

endmodule

// File: doc/shape_seq_ctrl.md
Name: shape_seq_ctrl

Overview:
- Sequencing controller for the OLED shape-display datapath (circle/square/doughnut renderers and the border overlay).
- Debounces up/down buttons, adds hold-to-repeat, and keeps a pending 3-bit shape index.
- Commits that index to the pixel mux only on a frame boundary, so a shape never changes mid-frame.
- Sits between the button inputs and the 25 MHz pixel-colour mux; replaces ad-hoc counters in the display task.

Parameters:
- DEBOUNCE_MS, 200, consecutive tick_1k periods an input must differ from its accepted level before the new level is accepted.
- REPEAT_DELAY_MS, 500, ticks a button is held after its accepted press before the first auto-repeat step.
- REPEAT_RATE_MS, 150, ticks between successive auto-repeat steps.
- FRAME_PIXELS, 6144, pixels per frame (96x64); pixel_index values at or above this are ignored.

Ports:
- clk  in  1  system clock (pixel domain, 25 MHz).
- rst  in  1  synchronous, active-high reset.
- tick_1k  in  1  one-clk-wide enable pulse at 1 kHz, synchronous to clk.
- btn_up  in  1  raw up button, already synchronised to clk.
- btn_down  in  1  raw down button, already synchronised to clk.
- pixel_index  in  13  current OLED pixel index, 0..6143.
- shape_sel  out  3  committed shape index: 0 blank, 1-3 green/orange/red circle, 4-6 green/orange/red square, 7 blank.
- doughnut_white  out  1  1 when shape_sel is 4..6, otherwise 0 (orange).
- pending_sel  out  3  index that will be committed at the next frame start.
- commit_pulse  out  1  one clk high when shape_sel is loaded.

Behaviour:
- Reset: shape_sel=0, pending_sel=0, doughnut_white=0, commit_pulse=0; both debouncers accepted-low with counters 0; FSM in IDLE. Reset mid-hold: the hold is forgotten and no step is issued.
- Debounce (per button), evaluated only when tick_1k=1:
  - raw == accepted: counter cleared.
  - raw != accepted: counter+1. The tick on which the counter reaches DEBOUNCE_MS-1 flips accepted and clears the counter.
  - An accepted 0->1 transition emits a one-clk press strobe.
  - Any bounce back to the accepted level clears the counter.
- FSM states IDLE, HOLD, REPEAT; tracks a direction bit dir (up/down):
  - IDLE -> HOLD on a press strobe: latch dir, step once, clear hold_cnt.
  - HOLD: hold_cnt counts tick_1k. At REPEAT_DELAY_MS: step once, clear hold_cnt, go to REPEAT.
  - REPEAT: step every REPEAT_RATE_MS ticks.
  - HOLD or REPEAT -> IDLE when the accepted level of the latched button is 0. No step is issued on release.
  - While in HOLD or REPEAT, a press of the other button is ignored.
- Simultaneous strobes in IDLE (both in the same clk): no step; stay IDLE.
- Step arithmetic on pending_sel, mod 8: up 7->0, down 0->7.
- Frame commit:
  - frame_start = (pixel_index==0) and (previous pixel_index!=0). The previous value is registered; its reset value is 0.
  - On frame_start: shape_sel<=pending_sel, doughnut_white<=(pending_sel in 4..6), commit_pulse=1 for one clk. Commit happens even if the value is unchanged.
  - A step and a frame_start in the same clk: the commit takes the pre-step pending_sel; the step lands in the next frame.
  - Multiple steps within one frame accumulate; only the final value is shown.
- Latency:
  - Press strobe is exactly DEBOUNCE_MS ticks after raw rises, provided raw stays stable.
  - pending_sel updates 1 clk after the strobe.
  - shape_sel updates at the next frame_start.

Decomposition:
- Shared package shape_pkg:
  - Shape index constants SHAPE_BLANK, SHAPE_CIRCLE_G..SHAPE_SQUARE_R.
  - OLED_W=96, OLED_H=64.
  - Colour constants: ORANGE 16'hFC00, GREEN 16'h07E0, RED 16'hF800, WHITE 16'hFFFF.
- Sub-module btn_debounce (clk, rst, tick_1k, raw, level, press), instantiated twice.

Test Plan:
- Power-up: rst high 3 clk with pixel_index sweeping -> shape_sel=0, pending_sel=0, doughnut_white=0, commit_pulse=0 throughout.
- Clean press: btn_up high 250 ticks, then a frame sweep -> strobe on tick 200, pending_sel=1; shape_sel=1 and commit_pulse=1 at the next pixel_index 6143->0 transition.
- Bounce: btn_up toggled every 50 ticks for 1000 ticks, then low -> no strobe, pending_sel unchanged.
- Wrap: from pending_sel=7, one up press -> 0. From 0, one down press -> 7 (after commit, doughnut_white=0).
- Auto-repeat: btn_up held 1200 ticks from pending_sel=0 -> steps at strobe, +500, +650, +800, +950, +1100 ticks; pending_sel=6, doughnut_white=1 after commit.
- Simultaneous and frame race: both buttons rise in the same clk -> no step. Separately, a step coinciding with frame_start -> shape_sel keeps the old value for that frame and takes the new one a frame later. rst asserted during REPEAT -> all outputs 0 and no further steps.
